pc_source_unit: RTL and testbench

Parametrised successor to the PC-source selection mux in the multicycle CPU datapath. It owns the PC register and the EPC register. Four-way next-PC selection now zero-extends the exception vector correctly. A small FSM sequences exception entry: it captures EPC, waits a fixed memory-read latency for the vector byte, then loads the PC. It sits between the control unit, ALU, shift-left-2 jump path, and memory data output.

---
 rtl/pc_source_if.sv | 32 +++
 rtl/pc_source_unit.sv | 103 ++++++++++
 tb/tb_pc_source_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pc_source_if.sv
// Handshake/data bundle between the control/datapath side and the PC source unit.
interface pc_source_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned VEC_W  = 8
);
  logic [1:0]        pc_src_ctrl;
  logic              pc_write;
  logic              pc_write_cond;
  logic              cond_flag;
  logic              exc_req;
  logic [VEC_W-1:0]  exc_destiny;
  logic [DATA_W-1:0] epc_in;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] jump_target;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] epc_out;
  logic              exc_busy;
  logic              exc_done;

  modport master (
    output pc_src_ctrl, pc_write, pc_write_cond, cond_flag, exc_req,
           exc_destiny, epc_in, alu_out, jump_target,
    input  pc_out, pc_next, epc_out, exc_busy, exc_done
  );

  modport slave (
    input  pc_src_ctrl, pc_write, pc_write_cond, cond_flag, exc_req,
           exc_destiny, epc_in, alu_out, jump_target,
    output pc_out, pc_next, epc_out, exc_busy, exc_done
  );
endinterface

// File: rtl/pc_source_unit.sv
// PC/EPC register owner with four-way next-PC mux and an exception-entry
// sequencer that waits a fixed memory latency before loading the vector.
module pc_source_unit #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          VEC_W    = 8,
  parameter int unsigned          MEM_LAT  = 2,
  parameter logic [DATA_W-1:0]    RESET_PC = '0
) (
  input  logic        clk,
  input  logic        reset,
  pc_source_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  if (MEM_LAT < 1 || MEM_LAT > 15 || VEC_W < 1 || VEC_W > DATA_W) begin : g_bad_param
    $error("pc_source_unit: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXC_WAIT = 2'd1,
    EXC_LOAD = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  pc;
  logic [DATA_W-1:0]  epc;
  logic [DATA_W-1:0]  vec_ext;
  logic [DATA_W-1:0]  sel;
  logic               busy;
  logic               done;
  logic               pc_we;

  // Vector byte is always zero-extended to the full PC width.
  assign vec_ext = DATA_W'(bus.exc_destiny);

  always_comb begin
    sel = vec_ext;
    case (bus.pc_src_ctrl)
      2'b00:   sel = vec_ext;
      2'b01:   sel = epc;
      2'b10:   sel = bus.alu_out;
      2'b11:   sel = bus.jump_target;
      default: sel = vec_ext;
    endcase
  end

  assign pc_we = bus.pc_write | (bus.pc_write_cond & bus.cond_flag);

  // Exception entry takes priority over any PC write in the same IDLE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pc    <= RESET_PC;
      epc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.exc_req) begin
            epc   <= bus.epc_in;
            count <= CNT_W'(MEM_LAT - 1);
            state <= EXC_WAIT;
            busy  <= 1'b1;
          end else if (pc_we) begin
            pc <= sel;
          end
        end
        EXC_WAIT: begin
          if (count == '0) begin
            state <= EXC_LOAD;
            done  <= 1'b1;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        EXC_LOAD: begin
          pc    <= vec_ext;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_out   = pc;
  assign bus.pc_next  = sel;
  assign bus.epc_out  = epc;
  assign bus.exc_busy = busy;
  assign bus.exc_done = done;

endmodule

// File: tb/tb_pc_source_unit.sv
// Directed and randomized checks of pc_source_unit against a cycle-count reference model.
module tb_pc_source_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned VEC_W   = 8;
  localparam int unsigned MEM_LAT = 2;
  localparam logic [31:0] RST_PC  = 32'h0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Reference model: phase = number of remaining busy cycles of an exception
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_epc;

  pc_source_if #(.DATA_W(DATA_W), .VEC_W(VEC_W)) bus ();

  pc_source_unit #(
    .DATA_W(DATA_W), .VEC_W(VEC_W), .MEM_LAT(MEM_LAT), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next();
    case (bus.pc_src_ctrl)
      2'b00:   return {24'h0, bus.exc_destiny};
      2'b01:   return m_epc;
      2'b10:   return bus.alu_out;
      default: return bus.jump_target;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_pc    = RST_PC;
    m_epc   = 32'h0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pc_out"},   bus.pc_out,   m_pc);
    chk({tag, ".epc_out"},  bus.epc_out,  m_epc);
    chk({tag, ".exc_busy"}, 32'(bus.exc_busy), 32'(m_phase != 0));
    chk({tag, ".exc_done"}, 32'(bus.exc_done), 32'(m_phase == 1));
  endtask

  // Inputs are already driven; check pc_next, advance one edge, check registers.
  task automatic tick(input string tag);
    logic [31:0] nxt_pc;
    logic [31:0] nxt_epc;
    int          nxt_phase;
    #1;
    chk({tag, ".pc_next"}, bus.pc_next, model_next());
    nxt_pc    = m_pc;
    nxt_epc   = m_epc;
    nxt_phase = m_phase;
    if (m_phase == 0) begin
      if (bus.exc_req) begin
        nxt_epc   = bus.epc_in;
        nxt_phase = int'(MEM_LAT) + 1;
      end else if (bus.pc_write || (bus.pc_write_cond && bus.cond_flag)) begin
        nxt_pc = model_next();
      end
    end else begin
      if (m_phase == 1) nxt_pc = {24'h0, bus.exc_destiny};
      nxt_phase = m_phase - 1;
    end
    @(posedge clk);
    m_pc    = nxt_pc;
    m_epc   = nxt_epc;
    m_phase = nxt_phase;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.pc_src_ctrl   = 2'b00;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.cond_flag     = 1'b0;
    bus.exc_req       = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    bus.exc_destiny = '0;
    bus.epc_in      = '0;
    bus.alu_out     = '0;
    bus.jump_target = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;

    // ALU write, then branch not taken and taken
    bus.pc_src_ctrl = 2'b10; bus.alu_out = 32'h40; bus.pc_write = 1'b1;
    tick("alu_wr");
    chk("alu_wr.const", bus.pc_out, 32'h40);
    bus.pc_write = 1'b0; bus.pc_write_cond = 1'b1; bus.cond_flag = 1'b0;
    bus.pc_src_ctrl = 2'b11; bus.jump_target = 32'h100;
    tick("br_not_taken");
    chk("br_not_taken.const", bus.pc_out, 32'h40);
    bus.cond_flag = 1'b1;
    tick("br_taken");
    chk("br_taken.const", bus.pc_out, 32'h100);

    // Vector select zero-extends
    idle_inputs();
    bus.exc_destiny = 8'hFF; bus.pc_write = 1'b1;
    tick("vec_sel");
    chk("vec_sel.const", bus.pc_out, 32'h0000_00FF);

    // Exception entry has priority over pc_write
    bus.pc_src_ctrl = 2'b10; bus.alu_out = 32'h200;
    tick("pc_200");
    bus.exc_req = 1'b1; bus.epc_in = 32'h1FC; bus.exc_destiny = 8'hFE;
    tick("exc_acc");
    chk("exc_acc.epc", bus.epc_out, 32'h1FC);
    chk("exc_acc.pc", bus.pc_out, 32'h200);
    bus.exc_req = 1'b0;
    tick("exc_w1");
    bus.pc_write = 1'b0;
    tick("exc_w2");
    chk("exc_w2.done", 32'(bus.exc_done), 32'h1);
    bus.pc_write = 1'b1; bus.exc_req = 1'b1;
    tick("exc_load");
    chk("exc_load.pc", bus.pc_out, 32'hFE);

    // Return via EPC, then immediate second exception
    idle_inputs();
    bus.pc_src_ctrl = 2'b01; bus.pc_write = 1'b1;
    tick("eret");
    chk("eret.const", bus.pc_out, 32'h1FC);
    idle_inputs();
    bus.exc_req = 1'b1; bus.epc_in = 32'h300; bus.exc_destiny = 8'h80;
    tick("exc2_acc");
    bus.exc_req = 1'b0;
    for (int i = 0; i < int'(MEM_LAT) + 1; i++) tick("exc2_run");
    chk("exc2.pc", bus.pc_out, 32'h80);

    // Async reset during EXC_WAIT abandons the sequence
    bus.exc_req = 1'b1; bus.epc_in = 32'h444; bus.exc_destiny = 8'h11;
    tick("exc3_acc");
    bus.exc_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick("post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.pc_src_ctrl   = 2'($urandom_range(0, 3));
      bus.pc_write      = 1'($urandom_range(0, 1));
      bus.pc_write_cond = 1'($urandom_range(0, 1));
      bus.cond_flag     = 1'($urandom_range(0, 1));
      bus.exc_req       = ($urandom_range(0, 7) == 0);
      bus.exc_destiny   = 8'($urandom);
      bus.epc_in        = $urandom;
      bus.alu_out       = $urandom;
      bus.jump_target   = $urandom;
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
